// File: rtl/clock_disp_pkg.sv
// Shared definitions for the digital clock display path: scanner FSM states,
// BCD code constants and a small BCD helper.
package clock_disp_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  // 4'hF drives every 74LS42 output high, so no digit is enabled
  localparam logic [3:0] BCD_NONE   = 4'hF;
  localparam int         MAX_DIGITS = 10;

  function automatic logic bcd_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_scan_ctrl_scan_timer.sv
// Slot timer for the display scanner: counts clocks within one digit slot and
// flags the end of the blanking guard and the end of the slot.
module scan_timer #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = $clog2(SCAN_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic slot_end,
  output logic blank_end
);

  logic [CNT_W-1:0] cnt;

  // Held at zero while not running, so a slot always starts from a clean count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign slot_end  = run && (cnt == CNT_W'(SCAN_DIV - 1));
  assign blank_end = run && (cnt == CNT_W'(BLANK_CYCLES - 1));

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed digit scanner driving a 74LS42 digit decoder and the segment
// decoder, with a blanking guard at the start of every digit slot.
module bcd_scan_ctrl
  import clock_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              sel_bcd,
  output logic [3:0]              seg_bcd,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
    $error("bcd_scan_ctrl: NUM_DIGITS must be in 1..%0d", MAX_DIGITS);
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank_cycles
    $error("bcd_scan_ctrl: need 1 <= BLANK_CYCLES < SCAN_DIV");
  end

  logic [1:0]              state;
  logic [3:0]              idx;
  logic [4*NUM_DIGITS-1:0] pending;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pend_valid;
  logic                    run;
  logic                    slot_end;
  logic                    blank_end;
  logic                    last_idx;
  logic                    wrap;
  logic                    take_new;
  logic [3:0]              cur_digit;
  logic                    cur_mask;
  logic                    show_now;

  assign run      = en && (state != ST_IDLE);
  assign last_idx = (idx == 4'(NUM_DIGITS - 1));
  assign wrap     = (state == ST_SHOW) && slot_end && last_idx;
  assign take_new = pend_valid && (wrap || (en && state == ST_IDLE));

  scan_timer #(
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .slot_end (slot_end),
    .blank_end(blank_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else if (!en) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_BLANK;
          idx   <= '0;
        end
        ST_BLANK: begin
          if (blank_end) state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (slot_end) begin
            state <= ST_BLANK;
            idx   <= last_idx ? 4'd0 : idx + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // A load in the same cycle as a transfer stays pending: the later assignment wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      shadow     <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (take_new) begin
        shadow     <= pending;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pending    <= digits_in;
        pend_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    cur_digit = BCD_NONE;
    cur_mask  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == 4'(k)) begin
        cur_digit = shadow[4*k +: 4];
        cur_mask  = blank_mask[k];
      end
    end
  end

  assign show_now = en && (state == ST_SHOW) && !cur_mask && bcd_valid(cur_digit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_bcd    <= BCD_NONE;
      seg_bcd    <= BCD_NONE;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      sel_bcd    <= show_now ? idx : BCD_NONE;
      seg_bcd    <= show_now ? cur_digit : BCD_NONE;
      blank      <= !show_now;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed self-checking bench for bcd_scan_ctrl with 4 digits, 8-clock slots
// and a 2-clock blanking guard.
module tb_bcd_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          load;
  logic [15:0]   digits_in;
  logic [3:0]    blank_mask;
  logic [3:0]    sel_bcd;
  logic [3:0]    seg_bcd;
  logic          blank;
  logic          frame_done;

  int n_compared   = 0;
  int n_mismatched = 0;
  int frame_no     = 0;

  bcd_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .digits_in (digits_in),
    .blank_mask(blank_mask),
    .sel_bcd   (sel_bcd),
    .seg_bcd   (seg_bcd),
    .blank     (blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge
  task automatic applyStimulus(input logic r, input logic e, input logic l, input logic [15:0] d);
    rst_n     = r;
    en        = e;
    load      = l;
    digits_in = d;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic checkCycle(input string tag, input logic [3:0] s, input logic [3:0] g,
                            input logic b, input logic fd);
    checkOutput({tag, " sel"}, 16'(sel_bcd), 16'(s));
    checkOutput({tag, " seg"}, 16'(seg_bcd), 16'(g));
    checkOutput({tag, " blank"}, 16'(blank), 16'(b));
    checkOutput({tag, " frame_done"}, 16'(frame_done), 16'(fd));
  endtask

  task automatic checkDark(input string tag);
    checkCycle(tag, 4'hF, 4'hF, 1'b1, 1'b0);
  endtask

  // Output after scan clock c of a frame: slot (c-1)/8, guard for its first 2 clocks
  task automatic runFrame(input logic [15:0] digs, input logic [3:0] mask, input logic [3:0] dark,
                          input int n, input int load_at, input logic [15:0] load_val,
                          input int load_at2, input logic [15:0] load_val2);
    frame_no++;
    blank_mask = mask;
    for (int c = 1; c <= n; c++) begin
      int         ph;
      int         sl;
      logic       show;
      logic [3:0] es;
      logic [3:0] eg;
      if (c == load_at)       applyStimulus(1'b1, 1'b1, 1'b1, load_val);
      else if (c == load_at2) applyStimulus(1'b1, 1'b1, 1'b1, load_val2);
      else                    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
      ph   = (c - 1) % SD;
      sl   = (c - 1) / SD;
      show = (ph >= BC) && !dark[sl];
      es   = show ? 4'(sl) : 4'hF;
      eg   = show ? digs[sl*4 +: 4] : 4'hF;
      checkCycle($sformatf("f%0d c%0d", frame_no, c), es, eg, !show, c == ND * SD);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    load       = 1'b0;
    digits_in  = 16'h0000;
    blank_mask = 4'b0000;

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkDark("reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkDark("idle");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h4321);
    checkDark("idle load");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkDark("start");

    runFrame(16'h4321, 4'b0000, 4'b0000, 32, 0, 16'h0, 0, 16'h0);
    runFrame(16'h4321, 4'b0000, 4'b0000, 32, 12, 16'h9876, 0, 16'h0);
    runFrame(16'h9876, 4'b0000, 4'b0000, 32, 5, 16'hA876, 0, 16'h0);
    runFrame(16'hA876, 4'b0100, 4'b1100, 32, 0, 16'h0, 0, 16'h0);
    runFrame(16'hA876, 4'b0000, 4'b1000, 20, 0, 16'h0, 0, 16'h0);

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkDark("en off");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkDark("en off hold");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkDark("restart");

    runFrame(16'hA876, 4'b0000, 4'b1000, 32, 10, 16'h5555, 32, 16'h2222);
    runFrame(16'h5555, 4'b0000, 4'b0000, 32, 0, 16'h0, 0, 16'h0);
    runFrame(16'h2222, 4'b0000, 4'b0000, 12, 0, 16'h0, 0, 16'h0);

    applyStimulus(1'b0, 1'b1, 1'b1, 16'h7777);
    checkDark("reset mid show");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    checkDark("post reset start");
    runFrame(16'h0000, 4'b0000, 4'b0000, 32, 0, 16'h0, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
